// File: rtl/barrel_pkg.sv
// Shared definitions for the barrel-threaded fetch stage and its execute-side
// redirect source.
package barrel_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          TID_W_MAX = 8;
  localparam int          XLEN      = 32;

  typedef struct packed {
    logic                 valid;
    logic [TID_W_MAX-1:0] tid;
    logic [XLEN-1:0]      target;
  } redirect_t;

  function automatic int thread_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/barrel_fetch_if.sv
// Instruction-memory, redirect and F/D pipeline signals of the fetch stage.
interface barrel_fetch_if
  import barrel_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BITS_THREADS  = 3
);
  logic [ADDRESS_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0]    imem_rdata;
  logic                     pc_src_e;
  logic [ADDRESS_WIDTH-1:0] pc_target_e;
  logic [BITS_THREADS-1:0]  tid_e;
  logic [DATA_WIDTH-1:0]    instr_f;
  logic [ADDRESS_WIDTH-1:0] pc_f;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_f;
  logic [BITS_THREADS-1:0]  tid_f;
  logic                     valid_f;

  modport master (
    output imem_addr, instr_f, pc_f, pc_plus4_f, tid_f, valid_f,
    input  imem_rdata, pc_src_e, pc_target_e, tid_e
  );

  modport slave (
    input  imem_addr, instr_f, pc_f, pc_plus4_f, tid_f, valid_f,
    output imem_rdata, pc_src_e, pc_target_e, tid_e
  );
endinterface

// File: rtl/barrel_fetch_pc_bank.sv
// Per-thread PC array: one read/increment slot plus a redirect write port that
// overrides the increment when both target the same thread.
module pc_bank
  import barrel_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     NUM_THREADS   = 8,
  parameter int                     BITS_THREADS  = thread_bits(NUM_THREADS),
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [ADDRESS_WIDTH-1:0] PC_STRIDE   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BITS_THREADS-1:0]  rd_idx,
  output logic [ADDRESS_WIDTH-1:0] rd_pc,
  input  logic                     inc_en,
  input  logic                     wr_en,
  input  logic [BITS_THREADS-1:0]  wr_idx,
  input  logic [ADDRESS_WIDTH-1:0] wr_pc
);

  logic [ADDRESS_WIDTH-1:0] pc [NUM_THREADS];

  assign rd_pc = pc[rd_idx];

  // Thread ids beyond NUM_THREADS-1 match no entry, so such redirects drop out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_THREADS; i++)
        pc[i] <= RESET_PC + PC_STRIDE * ADDRESS_WIDTH'(i);
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (wr_en && (wr_idx == BITS_THREADS'(i)))
          pc[i] <= wr_pc;
        else if (inc_en && (rd_idx == BITS_THREADS'(i)))
          pc[i] <= pc[i] + ADDRESS_WIDTH'(4);
      end
    end
  end

endmodule

// File: rtl/barrel_fetch.sv
// Round-robin fetch stage of the barrel-threaded RV32 pipeline; one slot per
// cycle in fixed thread order, registering the F/D outputs for decode.
module barrel_fetch
  import barrel_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       NUM_THREADS   = 8,
  parameter int                       BITS_THREADS  = thread_bits(NUM_THREADS),
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [ADDRESS_WIDTH-1:0] PC_STRIDE     = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic [NUM_THREADS-1:0] thread_active,
  barrel_fetch_if.master         bus
);

  logic [BITS_THREADS-1:0]  cnt;
  logic [ADDRESS_WIDTH-1:0] cur_pc;
  logic                     slot_active;
  logic                     redir_ok;
  redirect_t                redir;

  always_comb begin
    redir                            = '0;
    redir.valid                      = bus.pc_src_e;
    redir.tid[BITS_THREADS-1:0]      = bus.tid_e;
    redir.target[ADDRESS_WIDTH-1:0]  = bus.pc_target_e;
  end

  assign redir_ok      = redir.valid && (redir.tid < TID_W_MAX'(NUM_THREADS));
  assign slot_active   = thread_active[cnt];
  assign bus.imem_addr = cur_pc;

  pc_bank #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_THREADS   (NUM_THREADS),
    .BITS_THREADS  (BITS_THREADS),
    .RESET_PC      (RESET_PC),
    .PC_STRIDE     (PC_STRIDE)
  ) u_pc_bank (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (cnt),
    .rd_pc  (cur_pc),
    .inc_en (~stall & slot_active),
    .wr_en  (redir_ok),
    .wr_idx (redir.tid[BITS_THREADS-1:0]),
    .wr_pc  (redir.target[ADDRESS_WIDTH-1:0])
  );

  // Inactive slots still rotate through; they just emit a NOP bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      bus.instr_f    <= DATA_WIDTH'(NOP_INSTR);
      bus.pc_f       <= '0;
      bus.pc_plus4_f <= '0;
      bus.tid_f      <= '0;
      bus.valid_f    <= 1'b0;
    end else if (!stall) begin
      cnt            <= (cnt == BITS_THREADS'(NUM_THREADS - 1)) ? '0 : cnt + 1'b1;
      bus.tid_f      <= cnt;
      bus.pc_f       <= cur_pc;
      bus.pc_plus4_f <= cur_pc + ADDRESS_WIDTH'(4);
      bus.instr_f    <= slot_active ? bus.imem_rdata : DATA_WIDTH'(NOP_INSTR);
      bus.valid_f    <= slot_active;
    end
  end

endmodule

// File: tb/tb_barrel_fetch.sv
// Directed bench for barrel_fetch: 8-thread main instance plus 4-thread
// (PC wrap) and 6-thread (non-power-of-2 rotation) instances.
module tb_barrel_fetch;
  import barrel_pkg::*;

  localparam logic [31:0] PAT = 32'hDEAD_0000;

  logic       clk;
  logic       rst;
  logic       stall;
  logic [7:0] ta8;
  logic [3:0] ta4;
  logic [5:0] ta6;
  int         nVectors;
  int         nMiscompares;

  barrel_fetch_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .BITS_THREADS(3)) bus8 ();
  barrel_fetch_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .BITS_THREADS(2)) bus4 ();
  barrel_fetch_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .BITS_THREADS(3)) bus6 ();

  assign bus8.imem_rdata = bus8.imem_addr ^ PAT;
  assign bus4.imem_rdata = bus4.imem_addr ^ PAT;
  assign bus6.imem_rdata = bus6.imem_addr ^ PAT;

  barrel_fetch #(
    .NUM_THREADS(8), .RESET_PC(32'h0000_0100), .PC_STRIDE(32'h0000_0040)
  ) dut8 (.clk(clk), .rst(rst), .stall(stall), .thread_active(ta8), .bus(bus8));

  barrel_fetch #(
    .NUM_THREADS(4), .RESET_PC(32'hFFFF_FFFC), .PC_STRIDE(32'h0000_0000)
  ) dut4 (.clk(clk), .rst(rst), .stall(1'b0), .thread_active(ta4), .bus(bus4));

  barrel_fetch #(
    .NUM_THREADS(6), .RESET_PC(32'h0000_0000), .PC_STRIDE(32'h0000_0010)
  ) dut6 (.clk(clk), .rst(rst), .stall(1'b0), .thread_active(ta6), .bus(bus6));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    assert (obs === exp)
    else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [7:0] ta, input logic src,
                               input logic [2:0] tid, input logic [31:0] tgt);
    stall            = st;
    ta8              = ta;
    bus8.pc_src_e    = src;
    bus8.tid_e       = tid;
    bus8.pc_target_e = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] expPc;
    nVectors     = 0;
    nMiscompares = 0;
    rst          = 1'b1;
    ta4          = '1;
    ta6          = '1;
    bus4.pc_src_e = 1'b0; bus4.tid_e = '0; bus4.pc_target_e = '0;
    bus6.pc_src_e = 1'b0; bus6.tid_e = '0; bus6.pc_target_e = '0;
    applyStimulus(1'b0, 8'hFF, 1'b0, 3'd0, 32'h0);
    #1;
    checkOutput("rst_instr", bus8.instr_f, 32'h0000_0013);
    checkOutput("rst_pc", bus8.pc_f, 32'h0);
    checkOutput("rst_pc4", bus8.pc_plus4_f, 32'h0);
    checkOutput("rst_tid", 32'(bus8.tid_f), 32'h0);
    checkOutput("rst_valid", 32'(bus8.valid_f), 32'h0);
    checkOutput("rst_addr", bus8.imem_addr, 32'h0000_0100);
    #1;
    rst = 1'b0;

    // Two full rotations, all threads active
    for (int k = 0; k < 16; k++) begin
      tick();
      expPc = 32'h100 + 32'h40 * 32'(k % 8) + 32'(4 * (k / 8));
      checkOutput("rot_tid", 32'(bus8.tid_f), 32'(k % 8));
      checkOutput("rot_pc", bus8.pc_f, expPc);
      checkOutput("rot_pc4", bus8.pc_plus4_f, expPc + 32'd4);
      checkOutput("rot_valid", 32'(bus8.valid_f), 32'h1);
      checkOutput("rot_instr", bus8.instr_f, expPc ^ PAT);
      expPc = 32'hFFFF_FFFC + 32'(4 * (k / 4));
      checkOutput("wrap4_tid", 32'(bus4.tid_f), 32'(k % 4));
      checkOutput("wrap4_pc", bus4.pc_f, expPc);
      checkOutput("wrap4_pc4", bus4.pc_plus4_f, expPc + 32'd4);
      expPc = 32'h10 * 32'(k % 6) + 32'(4 * (k / 6));
      checkOutput("nt6_tid", 32'(bus6.tid_f), 32'(k % 6));
      checkOutput("nt6_pc", bus6.pc_f, expPc);
    end

    // Thread 2 inactive for three rotations
    pulseReset();
    applyStimulus(1'b0, 8'b1111_1011, 1'b0, 3'd0, 32'h0);
    for (int j = 0; j < 24; j++) begin
      tick();
      checkOutput("inact_tid", 32'(bus8.tid_f), 32'(j % 8));
      if (j % 8 == 2) begin
        checkOutput("inact_pc", bus8.pc_f, 32'h180);
        checkOutput("inact_valid", 32'(bus8.valid_f), 32'h0);
        checkOutput("inact_instr", bus8.instr_f, 32'h0000_0013);
      end else begin
        expPc = 32'h100 + 32'h40 * 32'(j % 8) + 32'(4 * (j / 8));
        checkOutput("act_pc", bus8.pc_f, expPc);
        checkOutput("act_valid", 32'(bus8.valid_f), 32'h1);
      end
    end

    // Redirect thread 3 during its own slot
    pulseReset();
    applyStimulus(1'b0, 8'hFF, 1'b0, 3'd0, 32'h0);
    repeat (3) tick();
    applyStimulus(1'b0, 8'hFF, 1'b1, 3'd3, 32'h800);
    tick();
    checkOutput("redir_old_tid", 32'(bus8.tid_f), 32'd3);
    checkOutput("redir_old_pc", bus8.pc_f, 32'h1C0);
    applyStimulus(1'b0, 8'hFF, 1'b0, 3'd0, 32'h0);
    repeat (7) tick();
    tick();
    checkOutput("redir_new_tid", 32'(bus8.tid_f), 32'd3);
    checkOutput("redir_new_pc", bus8.pc_f, 32'h800);
    checkOutput("redir_new_pc4", bus8.pc_plus4_f, 32'h804);
    checkOutput("redir_new_instr", bus8.instr_f, 32'h800 ^ PAT);

    // Stall three cycles with a redirect to thread 5 inside the stall
    pulseReset();
    repeat (2) tick();
    applyStimulus(1'b1, 8'hFF, 1'b1, 3'd5, 32'hA00);
    tick();
    applyStimulus(1'b1, 8'hFF, 1'b0, 3'd0, 32'h0);
    for (int s = 0; s < 3; s++) begin
      if (s > 0) tick();
      checkOutput("stall_tid", 32'(bus8.tid_f), 32'd1);
      checkOutput("stall_pc", bus8.pc_f, 32'h140);
      checkOutput("stall_addr", bus8.imem_addr, 32'h180);
    end
    applyStimulus(1'b0, 8'hFF, 1'b0, 3'd0, 32'h0);
    tick();
    checkOutput("resume_tid", 32'(bus8.tid_f), 32'd2);
    checkOutput("resume_pc", bus8.pc_f, 32'h180);
    repeat (2) tick();
    checkOutput("resume4_pc", bus8.pc_f, 32'h200);
    tick();
    checkOutput("stall_redir_tid", 32'(bus8.tid_f), 32'd5);
    checkOutput("stall_redir_pc", bus8.pc_f, 32'hA00);
    checkOutput("stall_redir_pc4", bus8.pc_plus4_f, 32'hA04);

    // Asynchronous reset between edges
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_tid", 32'(bus8.tid_f), 32'h0);
    checkOutput("arst_pc", bus8.pc_f, 32'h0);
    checkOutput("arst_pc4", bus8.pc_plus4_f, 32'h0);
    checkOutput("arst_valid", 32'(bus8.valid_f), 32'h0);
    checkOutput("arst_instr", bus8.instr_f, 32'h0000_0013);
    checkOutput("arst_addr", bus8.imem_addr, 32'h100);
    checkOutput("arst6_pc", bus6.pc_f, 32'h0);
    checkOutput("arst6_addr", bus6.imem_addr, 32'h0);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_tid", 32'(bus8.tid_f), 32'h0);
    checkOutput("post_rst_pc", bus8.pc_f, 32'h100);
    checkOutput("post_rst_valid", 32'(bus8.valid_f), 32'h1);
    checkOutput("post_rst6_pc", bus6.pc_f, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
